// File: rtl/cp0_unit.sv
// rtl/cp0_unit.sv - CP0 register block: Status/Cause/EPC/Count/Compare, interrupt sync and timer
module cp0_unit #(
    parameter logic [31:0] HANDLER_ADDR = 32'h0000_0004,
    parameter int          NUM_HW_INT   = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cp0_we,
    input  logic [1:0]            cp0_dst,
    input  logic [2:0]            cause_code,
    input  logic [2:0]            data_sel,
    input  logic                  eret,
    input  logic [4:0]            rd_addr,
    input  logic [31:0]           gpr_data,
    input  logic [31:0]           pc_in,
    input  logic [NUM_HW_INT-1:0] hw_int,
    output logic [31:0]           rdata,
    output logic [31:0]           epc_out,
    output logic [31:0]           handler_addr,
    output logic                  int_req,
    output logic                  exl,
    output logic                  timer_irq
);

    localparam logic [4:0] IDX_COUNT   = 5'd9;
    localparam logic [4:0] IDX_COMPARE = 5'd11;
    localparam logic [4:0] IDX_STATUS  = 5'd12;
    localparam logic [4:0] IDX_CAUSE   = 5'd13;
    localparam logic [4:0] IDX_EPC     = 5'd14;

    logic                  ie_q, ie_d;
    logic                  exl_q, exl_d;
    logic [2:0]            im_q, im_d;
    logic [2:0]            ip_q, ip_d;
    logic [4:0]            exc_q, exc_d;
    logic [31:0]           epc_q, epc_d;
    logic [31:0]           count_q, count_d;
    logic [31:0]           compare_q, compare_d;
    logic                  int_req_q, int_req_d;
    logic [NUM_HW_INT-1:0] sync1_q, sync2_q, sync3_q;
    logic [NUM_HW_INT-1:0] hw_edge;
    logic                  mtc0;

    assign hw_edge = sync2_q & ~sync3_q;
    assign mtc0    = cp0_we && (cp0_dst == 2'b00);

    always_comb begin
        ie_d      = ie_q;
        exl_d     = exl_q;
        im_d      = im_q;
        ip_d      = ip_q;
        exc_d     = exc_q;
        epc_d     = epc_q;
        count_d   = count_q + 32'd1;
        compare_d = compare_q;

        if (count_q == compare_q) begin
            ip_d[2] = 1'b1;
        end

        if (mtc0) begin
            case (rd_addr)
                IDX_COUNT:   count_d = gpr_data;
                IDX_COMPARE: begin
                    compare_d = gpr_data;
                    ip_d[2]   = 1'b0;
                end
                IDX_STATUS: begin
                    ie_d  = gpr_data[0];
                    exl_d = gpr_data[1];
                    im_d  = gpr_data[12:10];
                end
                IDX_CAUSE:   ip_d[1:0] = gpr_data[11:10];
                IDX_EPC:     epc_d = gpr_data;
                default: ;
            endcase
        end

        // Edge-set beats a same-cycle software clear of the IP bit.
        for (int i = 0; i < NUM_HW_INT; i++) begin
            if (hw_edge[i]) begin
                ip_d[i] = 1'b1;
            end
        end

        if (cp0_we && (cp0_dst == 2'b01)) begin
            case (data_sel)
                3'b000:  epc_d = gpr_data;
                3'b001:  epc_d = pc_in;
                3'b010:  epc_d = pc_in - 32'd4;
                default: epc_d = 32'd0;
            endcase
        end

        if (cp0_we && (cp0_dst == 2'b10)) begin
            exc_d = {2'b00, cause_code};
        end

        // Exception entry takes priority over a coincident eret.
        if (eret) begin
            exl_d = 1'b0;
        end
        if (cp0_we && (cp0_dst == 2'b11)) begin
            exl_d = 1'b1;
        end

        int_req_d = ie_q & ~exl_q & (|(ip_q & im_q));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ie_q      <= 1'b0;
            exl_q     <= 1'b0;
            im_q      <= 3'b000;
            ip_q      <= 3'b000;
            exc_q     <= 5'd0;
            epc_q     <= 32'd0;
            count_q   <= 32'd0;
            compare_q <= 32'hFFFF_FFFF;
            int_req_q <= 1'b0;
            sync1_q   <= '0;
            sync2_q   <= '0;
            sync3_q   <= '0;
        end else begin
            ie_q      <= ie_d;
            exl_q     <= exl_d;
            im_q      <= im_d;
            ip_q      <= ip_d;
            exc_q     <= exc_d;
            epc_q     <= epc_d;
            count_q   <= count_d;
            compare_q <= compare_d;
            int_req_q <= int_req_d;
            sync1_q   <= hw_int;
            sync2_q   <= sync1_q;
            sync3_q   <= sync2_q;
        end
    end

    always_comb begin
        rdata = 32'd0;
        case (rd_addr)
            IDX_COUNT:   rdata = count_q;
            IDX_COMPARE: rdata = compare_q;
            IDX_STATUS:  rdata = {19'd0, im_q, 8'd0, exl_q, ie_q};
            IDX_CAUSE:   rdata = {19'd0, ip_q, 3'd0, exc_q, 2'd0};
            IDX_EPC:     rdata = epc_q;
            default:     rdata = 32'd0;
        endcase
    end

    assign epc_out      = epc_q;
    assign handler_addr = HANDLER_ADDR;
    assign int_req      = int_req_q;
    assign exl          = exl_q;
    assign timer_irq    = ip_q[2];

endmodule

// File: tb/tb_cp0_unit.sv
// tb/tb_cp0_unit.sv - directed self-checking bench for cp0_unit
`timescale 1ns/100ps
module tb_cp0_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        cp0_we;
    logic [1:0]  cp0_dst;
    logic [2:0]  cause_code;
    logic [2:0]  data_sel;
    logic        eret;
    logic [4:0]  rd_addr;
    logic [31:0] gpr_data;
    logic [31:0] pc_in;
    logic [1:0]  hw_int;
    logic [31:0] rdata;
    logic [31:0] epc_out;
    logic [31:0] handler_addr;
    logic        int_req;
    logic        exl;
    logic        timer_irq;

    int checks = 0;
    int errors = 0;

    cp0_unit dut (
        .clk(clk), .reset(reset), .cp0_we(cp0_we), .cp0_dst(cp0_dst),
        .cause_code(cause_code), .data_sel(data_sel), .eret(eret),
        .rd_addr(rd_addr), .gpr_data(gpr_data), .pc_in(pc_in),
        .hw_int(hw_int), .rdata(rdata), .epc_out(epc_out),
        .handler_addr(handler_addr), .int_req(int_req), .exl(exl),
        .timer_irq(timer_irq)
    );

    always #10 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic steps(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic rd(input logic [4:0] a, input string tag, input logic [31:0] exp);
        rd_addr = a;
        #1;
        chk(tag, rdata, exp);
    endtask

    task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
        cp0_we = 1'b1; cp0_dst = 2'b00; rd_addr = a; gpr_data = d;
        step();
        cp0_we = 1'b0;
    endtask

    task automatic cp0w(input logic [1:0] dst);
        cp0_we = 1'b1; cp0_dst = dst;
        step();
        cp0_we = 1'b0;
    endtask

    initial begin
        reset = 1'b1; cp0_we = 1'b0; cp0_dst = 2'b00; cause_code = 3'd0;
        data_sel = 3'd0; eret = 1'b0; rd_addr = 5'd0; gpr_data = 32'd0;
        pc_in = 32'd0; hw_int = 2'b00;
        #25;
        chk("rst_int_req", {31'd0, int_req}, 32'd0);
        chk("rst_exl", {31'd0, exl}, 32'd0);
        chk("handler_addr", handler_addr, 32'h0000_0004);
        reset = 1'b0;
        rd(5'd9, "rst_count0", 32'd0);
        step();
        rd(5'd9, "count_run", 32'd1);
        rd(5'd11, "rst_compare", 32'hFFFF_FFFF);
        rd(5'd12, "rst_status", 32'd0);
        rd(5'd13, "rst_cause", 32'd0);
        rd(5'd14, "rst_epc", 32'd0);
        rd(5'd3, "unimpl_idx", 32'd0);

        // keyboard interrupt through synchroniser
        mtc0(5'd12, 32'h0000_0401);
        rd(5'd12, "status_wr", 32'h0000_0401);
        hw_int = 2'b01;
        step(); rd(5'd13, "ip0_e1", 32'd0);
        step(); rd(5'd13, "ip0_e2", 32'd0);
        step(); rd(5'd13, "ip0_e3", 32'h0000_0400);
        chk("int_req_e3", {31'd0, int_req}, 32'd0);
        step();
        chk("int_req_e4", {31'd0, int_req}, 32'd1);
        cp0w(2'b11);
        chk("exl_entry", {31'd0, exl}, 32'd1);
        step();
        chk("int_req_exl", {31'd0, int_req}, 32'd0);
        eret = 1'b1; step(); eret = 1'b0;
        chk("exl_eret", {31'd0, exl}, 32'd0);
        chk("int_req_eret0", {31'd0, int_req}, 32'd0);
        step();
        chk("int_req_eret1", {31'd0, int_req}, 32'd1);
        rd(5'd12, "status_after_eret", 32'h0000_0401);
        rd(5'd14, "epc_after_eret", 32'd0);
        cp0_we = 1'b1; cp0_dst = 2'b11; eret = 1'b1;
        step();
        cp0_we = 1'b0; eret = 1'b0;
        chk("entry_beats_eret", {31'd0, exl}, 32'd1);
        eret = 1'b1; step(); eret = 1'b0;
        mtc0(5'd13, 32'd0);
        steps(4);
        rd(5'd13, "held_level_once", 32'd0);
        chk("int_req_cleared", {31'd0, int_req}, 32'd0);
        hw_int = 2'b00;

        // timer
        mtc0(5'd9, 32'd10);
        mtc0(5'd11, 32'd15);
        rd(5'd9, "count_load", 32'd11);
        steps(4);
        rd(5'd9, "count_at_match", 32'd15);
        chk("timer_pre", {31'd0, timer_irq}, 32'd0);
        step();
        chk("timer_set", {31'd0, timer_irq}, 32'd1);
        rd(5'd13, "cause_ip2", 32'h0000_1000);
        mtc0(5'd11, 32'd100);
        chk("timer_clr", {31'd0, timer_irq}, 32'd0);
        mtc0(5'd9, 32'd10);
        mtc0(5'd11, 32'd15);
        steps(4);
        rd(5'd9, "count_match2", 32'd15);
        mtc0(5'd11, 32'd15);
        chk("timer_wr_wins", {31'd0, timer_irq}, 32'd0);
        step();
        chk("timer_wr_wins2", {31'd0, timer_irq}, 32'd0);
        mtc0(5'd11, 32'h8000_0000);
        mtc0(5'd9, 32'hFFFF_FFFF);
        rd(5'd9, "count_max", 32'hFFFF_FFFF);
        step();
        rd(5'd9, "count_wrap", 32'd0);

        // EPC sources
        pc_in = 32'h0000_0040; gpr_data = 32'hDEAD_BEEF;
        data_sel = 3'b001; cp0w(2'b01); chk("epc_pc", epc_out, 32'h0000_0040);
        data_sel = 3'b010; cp0w(2'b01); chk("epc_pc4", epc_out, 32'h0000_003C);
        data_sel = 3'b000; cp0w(2'b01); chk("epc_gpr", epc_out, 32'hDEAD_BEEF);
        rd(5'd14, "epc_rd", 32'hDEAD_BEEF);
        pc_in = 32'd0;
        data_sel = 3'b010; cp0w(2'b01); chk("epc_pc4_wrap", epc_out, 32'hFFFF_FFFC);
        data_sel = 3'b011; cp0w(2'b01); chk("epc_other", epc_out, 32'd0);

        // Cause ExcCode and set-beats-clear
        hw_int = 2'b01;
        steps(3);
        rd(5'd13, "cause_ip0", 32'h0000_0400);
        cause_code = 3'b101; cp0w(2'b10);
        rd(5'd13, "cause_exc", 32'h0000_0414);
        hw_int = 2'b11;
        steps(2);
        mtc0(5'd13, 32'd0);
        rd(5'd13, "set_beats_clr", 32'h0000_0814);

        // async reset with state loaded
        mtc0(5'd13, 32'h0000_0C00);
        mtc0(5'd11, 32'd60);
        mtc0(5'd9, 32'd58);
        steps(3);
        rd(5'd13, "ip_all", 32'h0000_1C14);
        cp0w(2'b11);
        chk("exl_pre_rst", {31'd0, exl}, 32'd1);
        hw_int = 2'b00;
        #3 reset = 1'b1;
        #1;
        chk("arst_exl", {31'd0, exl}, 32'd0);
        chk("arst_timer", {31'd0, timer_irq}, 32'd0);
        chk("arst_int_req", {31'd0, int_req}, 32'd0);
        chk("arst_epc", epc_out, 32'd0);
        rd(5'd13, "arst_cause", 32'd0);
        rd(5'd12, "arst_status", 32'd0);
        @(negedge clk);
        reset = 1'b0;
        rd(5'd9, "rel_count", 32'd0);
        rd(5'd11, "rel_compare", 32'hFFFF_FFFF);
        step();
        rd(5'd9, "rel_count1", 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cp0_unit.md
Name: cp0_unit

Overview:
- Coprocessor-0 register block for the multi-cycle MIPS core.
- Sits directly downstream of the main control FSM. It consumes the FSM's CP0Write / CP0Dst / Cause / DatatoCP0 strobes and holds the Status, Cause, EPC, Count and Compare registers.
- Latches and synchronises external interrupt lines and runs the timer.
- Returns three things to the datapath and FSM: the mfc0 read data, the EPC for eret, and a masked, registered interrupt request.

Parameters:
- HANDLER_ADDR, 32'h0000_0004, exception handler entry driven on handler_addr.
- NUM_HW_INT, 2, number of external interrupt lines (keyboard, counter).

Ports:
- clk  in  1  system clock, all state on rising edge.
- reset  in  1  asynchronous, active-high reset.
- cp0_we  in  1  CP0 write strobe from control FSM.
- cp0_dst  in  2  write target: 00 mtc0 register indexed by rd_addr; 01 EPC; 10 Cause.ExcCode; 11 exception entry (set Status.EXL).
- cause_code  in  3  exception code; written zero-extended into Cause[6:2] when cp0_dst=10.
- data_sel  in  3  EPC source: 000 gpr_data, 001 pc_in, 010 pc_in-4; others write 0.
- eret  in  1  single-cycle pulse: clear Status.EXL.
- rd_addr  in  5  CP0 register index for mtc0/mfc0.
- gpr_data  in  32  rt value for mtc0.
- pc_in  in  32  current PC.
- hw_int  in  NUM_HW_INT  asynchronous level interrupt lines; bit0 keyboard, bit1 counter.
- rdata  out  32  mfc0 read data, combinational on rd_addr.
- epc_out  out  32  EPC register.
- handler_addr  out  32  constant HANDLER_ADDR.
- int_req  out  1  registered, masked interrupt request to FSM.
- exl  out  1  Status.EXL.
- timer_irq  out  1  Cause.IP[2] (timer pending).

Behaviour:
- Registers and indices: Count=9, Compare=11, Status=12, Cause=13, EPC=14.
  - Status bit0 = IE, bit1 = EXL, bits[12:10] = IM; other Status bits read 0.
  - Cause bits[12:10] = IP, bits[6:2] = ExcCode; other Cause bits read 0.
  - Unimplemented index: mtc0 ignored, rdata = 0.
- Reset (async): Status = 0, Cause = 0, EPC = 0, Count = 0, Compare = 32'hFFFF_FFFF, sync flops = 0, int_req = 0.
  - Outputs after reset: rdata reflects the reset values; exl = 0, timer_irq = 0, int_req = 0.
- Write latency: every register write is visible on rdata/epc_out/exl the cycle after the cp0_we edge.
- hw_int path:
  - Each line passes through a 2-flop synchroniser plus an edge-detect flop.
  - A synchronised rising edge sets IP[i] for i = 0..NUM_HW_INT-1.
  - Earliest IP set is 3 edges after the input rises. A held level sets IP only once.
  - IP bits are cleared only by an mtc0 write to Cause, which writes IP[1:0] from gpr_data[11:10]; ExcCode is not writable by mtc0.
  - If an edge-set and a software clear occur in the same cycle, the set wins.
- Timer:
  - Count increments by 1 every cycle, wrapping 32'hFFFF_FFFF to 0.
  - An mtc0 to Count loads gpr_data instead of incrementing.
  - When Count == Compare, IP[2] is set on the next edge.
  - An mtc0 to Compare loads the value and clears IP[2]. If this coincides with a match in the same cycle, the write wins (IP[2] = 0).
- Exception entry (cp0_we, cp0_dst=11): EXL <= 1. If eret occurs in the same cycle, entry wins (EXL = 1).
- cp0_dst=01: EPC <= the value selected by data_sel. pc_in-4 is a 32-bit modulo subtraction.
- eret (no simultaneous entry): EXL <= 0 next edge. eret does not alter EPC or IE.
- int_req:
  - Registered as IE & ~EXL & |(IP & IM), computed from current register values, so there is 1 cycle of latency after the condition becomes true.
  - Drops the cycle after EXL sets.
- Writes to the same register from cp0_dst and mtc0 cannot coincide, since the FSM issues one per cycle.
- Reset mid-operation clears everything immediately, including pending IP bits and synchroniser state.

Test Plan:
- Reset, then mfc0 of indices 9/11/12/13/14 -> rdata = running Count, FFFF_FFFF, 0, 0, 0. int_req = 0, exl = 0.
- mtc0 Status = 32'h0000_0401 (IE=1, IM0=1); raise hw_int[0] and hold it -> Cause.IP0 = 1 after 3 edges, int_req = 1 one edge later. Then cp0_dst=11 -> exl = 1, int_req = 0 the next cycle. Then eret -> exl = 0, int_req = 1 again.
- mtc0 Count = 32'd10, mtc0 Compare = 32'd15 -> timer_irq = 1 the cycle after Count reads 15. mtc0 Compare = 32'd100 -> timer_irq = 0. Repeat with the Compare write landing on the match cycle -> timer_irq stays 0.
- pc_in = 32'h0000_0040, cp0_dst=01 with data_sel 001/010/000 (gpr_data = 32'hDEAD_BEEF) -> epc_out = 0x40, 0x3C, DEADBEEF respectively.
- cp0_dst=10 with cause_code = 3'b101 -> Cause[6:2] = 5'b00101 and IP untouched. Then mtc0 Cause with gpr_data = 0 while a hw_int[1] edge arrives in the same cycle -> IP1 = 1, IP0 = 0.
- Assert reset while exl = 1 and IP = 3'b111 -> all registers at reset values asynchronously. Count = 0 and Compare = FFFF_FFFF on release.
